// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-input priority pick: a lone requester wins, a tie goes to the port named by ptr.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  port_id_t   ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = (ptr == PORT1) ? 2'b10 : 2'b01;
        end else begin
            gnt = {req1, req0};
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with lockable ownership and registered read responses.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    port_id_t          pick_ptr;
    logic [1:0]        pick_gnt;

    logic              vld0_p1;
    logic              vld1_p1;
    logic [DATA_W-1:0] rdata0_p1;
    logic [DATA_W-1:0] rdata1_p1;

`ifdef DMEM_ARB_RR_EN
    port_id_t ptr_q;
    port_id_t ptr_nxt;

    // Only IDLE grants rotate the pointer; owned bursts leave it untouched.
    always_comb begin
        ptr_nxt = ptr_q;
        if (state == IDLE) begin
            if (gnt0) begin
                ptr_nxt = PORT1;
            end else if (gnt1) begin
                ptr_nxt = PORT0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = PORT0;
`endif

    dmem_arb_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .ptr  (pick_ptr),
        .gnt  (pick_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    gnt0 = pick_gnt[0];
                    gnt1 = pick_gnt[1];
                    if (gnt0 && lock0) begin
                        state_nxt = OWN0;
                    end else if (gnt1 && lock1) begin
                        state_nxt = OWN1;
                    end
                end
                OWN0: begin
                    gnt0 = req0;
                    if (!lock0 || !req0) begin
                        state_nxt = IDLE;
                    end
                end
                OWN1: begin
                    gnt1 = req1;
                    if (!lock1 || !req1) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_read  = ~we0;
            mem_write = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_read  = ~we1;
            mem_write = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // ---- stage p1: read response captured at the grant edge ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld0_p1   <= 1'b0;
            vld1_p1   <= 1'b0;
            rdata0_p1 <= '0;
            rdata1_p1 <= '0;
        end else begin
            vld0_p1 <= gnt0 & ~we0;
            vld1_p1 <= gnt1 & ~we1;
            if (gnt0 && !we0) begin
                rdata0_p1 <= mem_rdata;
            end
            if (gnt1 && !we1) begin
                rdata1_p1 <= mem_rdata;
            end
        end
    end

    // A response already registered when rst rises is hidden, not delivered.
    assign rvalid0 = vld0_p1 & ~rst;
    assign rvalid1 = vld1_p1 & ~rst;
    assign rdata0  = rst ? '0 : rdata0_p1;
    assign rdata1  = rst ? '0 : rdata1_p1;

endmodule
